// File: rtl/datain_sink.sv
// Flit sink: accepts flits into a show-ahead FIFO, counts accepts and drops, and ends the run after EXPECTED flits.
// Optional per-source sequence checker is enabled by defining SINK_SEQ_CHECK_EN.
`timescale 1ns/1ps

module datain_sink #(
    parameter int unsigned EXPECTED   = 30,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned NUM_SRC    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] datain,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        rd_en,
    output logic [19:0] rd_data,
    output logic        rd_valid,
    output logic [15:0] rx_count,
    output logic [15:0] drop_count,
    output logic [15:0] seq_err_count,
    output logic        done
);

    localparam int unsigned FLIT_W  = 20;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W   = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              full;
    logic              accept;
    logic              drop;
    logic              pop;
    logic              seq_err;

    assign full     = (occ == OCC_W'(FIFO_DEPTH));
    assign rd_valid = (occ != '0);
    assign rd_data  = mem[rd_ptr];
    // Readiness looks only at the current full flag; a same-cycle pop does not free a slot.
    assign in_ready = !rst && (state != S_DONE) && !full;
    assign accept   = in_valid && in_ready;
    assign drop     = in_valid && !in_ready;
    assign pop      = rd_en && rd_valid;
    assign done     = (state == S_DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RECV;
            S_RECV: if (rx_count >= CNT_W'(EXPECTED)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FIFO storage; contents are invalidated by the pointer reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= datain;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count      <= '0;
            drop_count    <= '0;
            seq_err_count <= '0;
        end else begin
            if (accept && (rx_count != CNT_MAX))        rx_count      <= rx_count + 16'd1;
            if (drop && (drop_count != CNT_MAX))        drop_count    <= drop_count + 16'd1;
            if (seq_err && (seq_err_count != CNT_MAX))  seq_err_count <= seq_err_count + 16'd1;
        end
    end

`ifdef SINK_SEQ_CHECK_EN
    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [7:0]       seq_tbl [NUM_SRC];
    logic [7:0]       in_src;
    logic [7:0]       in_seq;
    logic [IDX_W-1:0] tbl_idx;
    logic             src_ok;
    logic             seq_hit;

    assign in_src  = datain[19:12];
    assign in_seq  = datain[11:4];
    assign tbl_idx = in_src[IDX_W-1:0];
    assign src_ok  = (32'(in_src) < NUM_SRC);
    assign seq_hit = src_ok && (seq_tbl[tbl_idx] == in_seq);
    assign seq_err = accept && !seq_hit;

    // Expected-sequence table; a mismatch resyncs to the observed seq + 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                seq_tbl[i] <= 8'h01;
            end
        end else if (accept && src_ok) begin
            seq_tbl[tbl_idx] <= in_seq + 8'd1;
        end
    end
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_datain_sink.sv
// Directed bench for datain_sink: a default instance and an EXPECTED=40 instance share all inputs.
`timescale 1ns/1ps

module tb_datain_sink;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] datain = '0;
    logic        in_valid = 1'b0;
    logic        rd_en = 1'b0;

    logic        in_ready, rd_valid, done;
    logic [19:0] rd_data;
    logic [15:0] rx_count, drop_count, seq_err_count;

    logic        b_in_ready, b_rd_valid, b_done;
    logic [19:0] b_rd_data;
    logic [15:0] b_rx_count, b_drop_count, b_seq_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    datain_sink dut (
        .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid), .in_ready(in_ready),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rx_count(rx_count),
        .drop_count(drop_count), .seq_err_count(seq_err_count), .done(done)
    );

    datain_sink #(.EXPECTED(40), .FIFO_DEPTH(32), .NUM_SRC(16)) dut40 (
        .clk(clk), .rst(rst), .datain(datain), .in_valid(in_valid), .in_ready(b_in_ready),
        .rd_en(rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .rx_count(b_rx_count),
        .drop_count(b_drop_count), .seq_err_count(b_seq_err_count), .done(b_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; rd_en = 1'b0; datain = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; rd_en = 1'b0;
        step();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rx_count !== 16'd0) begin n_fail++; $display("FAIL reset_rx: got %0d want 0", rx_count); end
        n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        n_checks++; if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL reset_seq_err: got %0d want 0", seq_err_count); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        step();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_run();
        do_reset();
        rd_en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [19:0] f;
            f = {8'h03, 8'(i + 1), 4'(i % 4)};
            datain = f;
            step();
            n_checks++;
            if (rd_valid !== 1'b1 || rd_data !== f) begin
                n_fail++; $display("FAIL run_order[%0d]: got valid=%b data=%h want valid=1 data=%h", i, rd_valid, rd_data, f);
            end
        end
        in_valid = 1'b0;
        n_checks++; if (rx_count !== 16'd30) begin n_fail++; $display("FAIL run_rx_at_30th: got %0d want 30", rx_count); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL run_done_early: got %b want 0", done); end
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL run_done: got %b want 1", done); end
        n_checks++; if (rx_count !== 16'd30) begin n_fail++; $display("FAIL run_rx: got %0d want 30", rx_count); end
        n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL run_drop: got %0d want 0", drop_count); end
        n_checks++; if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL run_seq_err: got %0d want 0", seq_err_count); end
    endtask

    task automatic test_after_done();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL done_in_ready_before: got %b want 0", in_ready); end
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            datain = {8'h03, 8'(31 + i), 4'h0};
            step();
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (drop_count !== 16'd3) begin n_fail++; $display("FAIL done_drop: got %0d want 3", drop_count); end
        n_checks++; if (rx_count !== 16'd30) begin n_fail++; $display("FAIL done_rx: got %0d want 30", rx_count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL done_in_ready: got %b want 0", in_ready); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL done_sticky: got %b want 1", done); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL done_rd_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        rd_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 34; i++) begin
            datain = {8'h05, 8'(i + 1), 4'(i % 16)};
            step();
            if (i == 30) begin
                n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_31: got %b want 1", b_in_ready); end
            end
            if (i == 31) begin
                n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_32: got %b want 0", b_in_ready); end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (b_drop_count !== 16'd2) begin n_fail++; $display("FAIL fill_drop: got %0d want 2", b_drop_count); end
        n_checks++; if (b_rx_count !== 16'd32) begin n_fail++; $display("FAIL fill_rx: got %0d want 32", b_rx_count); end
        n_checks++; if (b_rd_valid !== 1'b1) begin n_fail++; $display("FAIL fill_rd_valid: got %b want 1", b_rd_valid); end
        n_checks++; if (b_rd_data !== 20'h05010) begin n_fail++; $display("FAIL fill_head: got %h want 05010", b_rd_data); end
        n_checks++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL fill_done: got %b want 0", b_done); end
        n_checks++; if (b_seq_err_count !== 16'd0) begin n_fail++; $display("FAIL fill_seq_err: got %0d want 0", b_seq_err_count); end
    endtask

    task automatic test_full_pop();
        in_valid = 1'b1; rd_en = 1'b1; datain = {8'h05, 8'd35, 4'h0};
        step();
        in_valid = 1'b0; rd_en = 1'b0;
        n_checks++; if (b_drop_count !== 16'd3) begin n_fail++; $display("FAIL fullpop_drop: got %0d want 3", b_drop_count); end
        n_checks++; if (b_rx_count !== 16'd32) begin n_fail++; $display("FAIL fullpop_rx: got %0d want 32", b_rx_count); end
        n_checks++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready: got %b want 1", b_in_ready); end
        n_checks++; if (b_rd_data !== 20'h05021) begin n_fail++; $display("FAIL fullpop_head: got %h want 05021", b_rd_data); end
        rd_en = 1'b1;
        for (int i = 0; i < 30; i++) step();
        n_checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 20'h0520F) begin
            n_fail++; $display("FAIL fullpop_last: got valid=%b data=%h want valid=1 data=0520F", b_rd_valid, b_rd_data);
        end
        step();
        n_checks++; if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b want 0", b_rd_valid); end
        step();
        n_checks++; if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_ignored: got %b want 0", b_rd_valid); end
        rd_en = 1'b0; in_valid = 1'b1; datain = 20'h05217;
        step();
        in_valid = 1'b0;
        n_checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 20'h05217) begin
            n_fail++; $display("FAIL wrap_push: got valid=%b data=%h want valid=1 data=05217", b_rd_valid, b_rd_data);
        end
        n_checks++; if (b_rx_count !== 16'd33) begin n_fail++; $display("FAIL wrap_rx: got %0d want 33", b_rx_count); end
        n_checks++; if (b_seq_err_count !== 16'd0) begin n_fail++; $display("FAIL wrap_seq_err: got %0d want 0", b_seq_err_count); end
    endtask

    task automatic test_seq();
        logic [19:0] vec [8];
        int          exp_err [8];
        vec = '{20'h03010, 20'h03020, 20'h03050, 20'h03060, 20'h20070, 20'h03070, 20'h04FF0, 20'h04000};
`ifdef SINK_SEQ_CHECK_EN
        exp_err = '{0, 0, 1, 1, 2, 2, 3, 3};
`else
        exp_err = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        rd_en = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            datain = vec[i];
            step();
            n_checks++;
            if (seq_err_count !== 16'(exp_err[i])) begin
                n_fail++; $display("FAIL seq_err[%0d]: got %0d want %0d", i, seq_err_count, exp_err[i]);
            end
        end
        in_valid = 1'b0;
        n_checks++; if (rx_count !== 16'd8) begin n_fail++; $display("FAIL seq_rx: got %0d want 8", rx_count); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        rd_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            datain = {8'h03, 8'(i + 1), 4'h0};
            step();
        end
        in_valid = 1'b0;
        n_checks++; if (rx_count !== 16'd10 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre: got rx=%0d valid=%b want rx=10 valid=1", rx_count, rd_valid);
        end
        rst = 1'b1; in_valid = 1'b1; datain = 20'h03010;
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (rx_count !== 16'd0) begin n_fail++; $display("FAIL mid_rx: got %0d want 0", rx_count); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
        step();
        n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL mid_drop: got %0d want 0", drop_count); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", done); end
        rst = 1'b0; in_valid = 1'b0;
        step();
        n_checks++; if (rx_count !== 16'd0) begin n_fail++; $display("FAIL mid_no_accept: got %0d want 0", rx_count); end
        in_valid = 1'b1; datain = 20'h03015;
        step();
        in_valid = 1'b0;
        n_checks++; if (rx_count !== 16'd1) begin n_fail++; $display("FAIL mid_restart_rx: got %0d want 1", rx_count); end
        n_checks++; if (seq_err_count !== 16'd0) begin n_fail++; $display("FAIL mid_restart_seq: got %0d want 0", seq_err_count); end
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 20'h03015) begin
            n_fail++; $display("FAIL mid_restart_data: got valid=%b data=%h want valid=1 data=03015", rd_valid, rd_data);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_after_done();
        test_fill();
        test_full_pop();
        test_seq();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
